product_bcd_conv: RTL
=====================

# product_bcd_conv

Sequential binary-to-BCD converter sitting directly downstream of the tt_um_carlosgs99 multiplier. It accepts the 2*bits-bit product over a valid/ready handshake and converts it with an iterative shift-and-add-3 (double-dabble) engine. It returns DIGITS packed BCD digits plus a leading-zero blanking mask for the 7-segment display stage.

## Interface
- bits, default 4, multiplier operand width; product width PW = 2*bits
- DIGITS, default 3, BCD digits produced; elaboration error unless 10^DIGITS > 2^PW − 1
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  product_i holds a product to convert
- in_ready  out  1  block can accept a product
- product_i  in  PW  unsigned product from multiplier (Product_o)
- out_valid  out  1  bcd_o / blank_o hold a completed result
- out_ready  in  1  downstream accepts result
- bcd_o  out  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]
- blank_o  out  DIGITS  bit d = 1 when digit d is a leading zero; bit 0 always 0

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready at a clock edge, the block loads the binary shift register with product_i, clears the BCD shift register and iteration counter, and goes to CONV. in_valid without ready has no effect.
- CONV: in_ready = 0 and in_valid is ignored. Each cycle, every BCD digit ≥ 5 gets +3. The {BCD, binary} register then shifts left 1 and the counter increments. After PW iterations (counter == PW−1 at the edge), the block goes to DONE.
- DONE: out_valid = 1, and bcd_o / blank_o are stable. On out_valid & out_ready, the block goes to IDLE. out_valid stays high until taken; there is no timeout.
- blank_o: digit d (d ≥ 1) is blanked iff it and all higher digits are zero. blank_o is computed from the final BCD value and registered with it.
- bcd_o / blank_o are registered. They update only on entry to DONE and hold their value through the following IDLE/CONV until the next result.
- Digit correction is 4-bit and cannot overflow a digit given the DIGITS constraint. No saturation is needed.

## Timing
- Reset (rst low, asynchronous): state = IDLE, out_valid = 0, bcd_o = 0, blank_o = all-ones except bit 0, counter = 0. While rst is low, in_ready = 0.
- Reset mid-CONV or in DONE aborts immediately. An untaken result is discarded and no out_valid is produced for it.
- Latency: accepting edge E → out_valid high after edge E+PW (8 cycles for bits=4).
- in_ready returns high the cycle after the output handshake edge. Throughput is one product per PW+2 cycles minimum.
- out_ready is ignored outside DONE. Holding out_ready high gives DONE a one-cycle duration.
- in_ready and out_valid are never high in the same cycle.

## Structure
- The shared package holds the state typedef (IDLE/CONV/DONE), a constant function computing the minimum DIGITS for a given PW (used by the elaboration check), and the counter width clog2(PW).
- One sub-module, bcd_digit_adj, is the combinational 4-bit "if ≥5 add 3" cell, instantiated DIGITS times.
- The top holds the FSM, counter, shift registers, blank-mask logic and output registers.

## Test plan
- Product 225 (15×15) accepted at edge E → out_valid at E+8, bcd_o = 0x225, blank_o = 3'b000.
- Product 7 → bcd_o = 0x007, blank_o = 3'b110. Product 0 → bcd_o = 0x000, blank_o = 3'b110. Product 100 → bcd_o = 0x100, blank_o = 3'b000.
- Back-pressure: product 42 with out_ready = 0 for 5 cycles:
  - out_valid and bcd_o = 0x042 stay stable;
  - in_ready stays 0;
  - after out_ready rises, in_ready = 1 on the next cycle.
- in_valid toggled with a different product (99) during CONV → ignored, result still matches the first product.
- rst pulsed low at iteration 4 of a conversion of 144 → outputs return to reset values immediately. Product 15 sent after release → bcd_o = 0x015, blank_o = 3'b100, and no stale result appears.
- Exhaustive sweep over all products i*j, i,j in 0..15, back-to-back with out_ready = 1 → every bcd_o equals the decimal product and the blank mask is correct.

Source files
------------

// File: rtl/product_bcd_conv_pkg.sv
// Shared types and elaboration helpers for the product-to-BCD converter.
package product_bcd_conv_pkg;

    localparam int DEF_BITS   = 4;
    localparam int DEF_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int min_digits(input int pw);
        longint maxv;
        longint p;
        int     d;
        maxv = (longint'(1) << pw) - 1;
        p    = 10;
        d    = 1;
        while (p <= maxv) begin
            p = p * 10;
            d = d + 1;
        end
        return d;
    endfunction

    function automatic int cnt_width(input int pw);
        return (pw <= 2) ? 1 : $clog2(pw);
    endfunction

endpackage

// File: rtl/product_bcd_conv_if.sv
// Input/output handshakes between multiplier, converter and display stage.
interface product_bcd_conv_if
    import product_bcd_conv_pkg::*;
#(
    parameter int PW     = 2 * DEF_BITS,
    parameter int DIGITS = DEF_DIGITS
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PW-1:0]         product_i;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_o;
    logic [DIGITS-1:0]     blank_o;

    modport master (
        output in_valid, product_i, out_ready,
        input  in_ready, out_valid, bcd_o, blank_o
    );

    modport slave (
        input  in_valid, product_i, out_ready,
        output in_ready, out_valid, bcd_o, blank_o
    );
endinterface

// File: rtl/product_bcd_conv_bcd_digit_adj.sv
// Double-dabble correction cell: a digit of 5 or more gets +3
// so the following left shift carries into the next decade.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/product_bcd_conv.sv
// Iterative binary-to-BCD converter with leading-zero blanking mask.
module product_bcd_conv
    import product_bcd_conv_pkg::*;
#(
    parameter int bits   = DEF_BITS,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic               clk,
    input  logic               rst,
    product_bcd_conv_if.slave  bus
);
    localparam int PW = 2 * bits;
    localparam int CW = cnt_width(PW);
    localparam int BW = 4 * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    if (DIGITS < min_digits(PW)) begin : g_digits_chk
        $error("DIGITS too small for product width");
    end

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       bin_q, bin_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [BW-1:0]       out_bcd_q, out_bcd_d;
    logic [DIGITS-1:0]   out_blank_q, out_blank_d;
    logic [BW-1:0]       adj;
    logic [BW+PW-1:0]    sh;
    logic [DIGITS-1:0]   blank_nx;
    logic                zero_run;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (bcd_q[4*g +: 4]),
            .d_o (adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        out_bcd_d   = out_bcd_q;
        out_blank_d = out_blank_q;
        sh          = {adj, bin_q} << 1;

        // A digit blanks only while it and every digit above it are zero.
        zero_run = 1'b1;
        blank_nx = '0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            zero_run    = zero_run & (sh[PW + 4*d +: 4] == 4'd0);
            blank_nx[d] = zero_run;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = CONV;
                    bin_d   = bus.product_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                bcd_d = sh[BW+PW-1:PW];
                bin_d = sh[PW-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(PW - 1)) begin
                    state_d     = DONE;
                    out_bcd_d   = sh[BW+PW-1:PW];
                    out_blank_d = blank_nx;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            out_bcd_q   <= '0;
            out_blank_q <= BLANK_RST;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            out_bcd_q   <= out_bcd_d;
            out_blank_q <= out_blank_d;
        end
    end

    assign bus.in_ready  = rst & (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.bcd_o     = out_bcd_q;
    assign bus.blank_o   = out_blank_q;

endmodule
